// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Shares the single register-file write port between NUM_REQ writeback
// sources using round-robin arbitration, and keeps a per-register busy
// scoreboard so decode can stall on reads of registers with pending writes.
// One write can be accepted every cycle.
//
// Ports
//   CLK, RST        clock and synchronous active-high reset
//   ISSUE_VALID     an instruction writing ISSUE_RD is issued this cycle
//   ISSUE_RD        destination register of the issued instruction
//   REQ_VALID       per-requester "result pending"
//   REQ_RD          packed destination addresses, slice i = [i*AW +: AW]
//   REQ_DATA        packed result data, slice i = [i*W +: W]
//   REQ_READY       one-hot grant (combinational), forced low during reset
//   RD_ADDRESS      registered write address to the register file
//   RD_DATA         registered write data to the register file
//   RD_WRITE_EN     registered write enable (never set for x0)
//   RS1/RS2_ADDRESS decode source addresses for the busy lookup
//   RS1/RS2_BUSY    source has a pending write not yet visible in the file
// ---------------------------------------------------------------------------
module rf_writeback_arbiter #(
    parameter int REGISTER_WIDTH = 32,
    parameter int REGISTER_DEPTH = 32,
    parameter int NUM_REQ        = 3,
    localparam int AW = $clog2(REGISTER_DEPTH),
    localparam int W  = REGISTER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ISSUE_VALID,
    input  logic [AW-1:0]         ISSUE_RD,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [NUM_REQ*AW-1:0] REQ_RD,
    input  logic [NUM_REQ*W-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]    REQ_READY,
    output logic [AW-1:0]         RD_ADDRESS,
    output logic [W-1:0]          RD_DATA,
    output logic                  RD_WRITE_EN,
    input  logic [AW-1:0]         RS1_ADDRESS,
    input  logic [AW-1:0]         RS2_ADDRESS,
    output logic                  RS1_BUSY,
    output logic                  RS2_BUSY
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]             ptr;
    logic [NUM_REQ-1:0]        grant;
    logic [PW-1:0]             grant_idx;
    logic                      transfer;
    logic [AW-1:0]             sel_rd;
    logic [W-1:0]              sel_data;
    logic [REGISTER_DEPTH-1:0] busy;
    logic [REGISTER_DEPTH-1:0] busy_nxt;

    // Round-robin pick: walk upward from the pointer with wrap and take the
    // first valid requester.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                   input logic [PW-1:0]      p);
        logic [NUM_REQ-1:0] g;
        logic [PW-1:0]      idx;
        logic               found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(p) + k) % NUM_REQ);
            if (!found && v[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // Grant is suppressed during reset so nothing is consumed that the
    // output stage would then drop.
    always_comb begin
        grant = RST ? '0 : rr_pick(REQ_VALID, ptr);
    end

    assign REQ_READY = grant;
    assign transfer  = |grant;

    // Encode the one-hot grant and mux the granted slice.
    always_comb begin
        grant_idx = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
            sel_rd   = sel_rd   | ({AW{grant[i]}} & REQ_RD[i*AW +: AW]);
            sel_data = sel_data | ({W{grant[i]}}  & REQ_DATA[i*W +: W]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Output stage: a write to x0 is consumed but never enabled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_WRITE_EN <= 1'b0;
            RD_ADDRESS  <= '0;
            RD_DATA     <= '0;
        end else if (transfer) begin
            RD_WRITE_EN <= (sel_rd != '0);
            RD_ADDRESS  <= sel_rd;
            RD_DATA     <= sel_data;
        end else begin
            RD_WRITE_EN <= 1'b0;
        end
    end

    // Scoreboard update: clear for the committing write first, then apply
    // the issue so a same-register set overrides the clear.
    always_comb begin
        busy_nxt = busy;
        if (RD_WRITE_EN) begin
            busy_nxt[RD_ADDRESS] = 1'b0;
        end
        if (ISSUE_VALID && (ISSUE_RD != '0)) begin
            busy_nxt[ISSUE_RD] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // The register file writes on the negedge, so a register being written
    // this cycle is already readable and must not stall decode.
    assign RS1_BUSY = (RS1_ADDRESS != '0) && busy[RS1_ADDRESS] &&
                      !(RD_WRITE_EN && (RD_ADDRESS == RS1_ADDRESS));
    assign RS2_BUSY = (RS2_ADDRESS != '0) && busy[RS2_ADDRESS] &&
                      !(RD_WRITE_EN && (RD_ADDRESS == RS2_ADDRESS));

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_arbiter
//
// Directed scenarios plus a randomized run for rf_writeback_arbiter. A
// behavioural model (pointer as an integer, busy bits as an array, expected
// write-port contents) is advanced once per clock alongside the design.
// ---------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int N  = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic           ISSUE_VALID;
    logic [AW-1:0]  ISSUE_RD;
    logic [N-1:0]   REQ_VALID;
    logic [N*AW-1:0] REQ_RD;
    logic [N*W-1:0] REQ_DATA;
    logic [N-1:0]   REQ_READY;
    logic [AW-1:0]  RD_ADDRESS;
    logic [W-1:0]   RD_DATA;
    logic           RD_WRITE_EN;
    logic [AW-1:0]  RS1_ADDRESS;
    logic [AW-1:0]  RS2_ADDRESS;
    logic           RS1_BUSY;
    logic           RS2_BUSY;

    int checks = 0;
    int passed = 0;

    rf_writeback_arbiter #(
        .REGISTER_WIDTH(W),
        .REGISTER_DEPTH(32),
        .NUM_REQ(N)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ISSUE_VALID(ISSUE_VALID),
        .ISSUE_RD(ISSUE_RD),
        .REQ_VALID(REQ_VALID),
        .REQ_RD(REQ_RD),
        .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .RD_ADDRESS(RD_ADDRESS),
        .RD_DATA(RD_DATA),
        .RD_WRITE_EN(RD_WRITE_EN),
        .RS1_ADDRESS(RS1_ADDRESS),
        .RS2_ADDRESS(RS2_ADDRESS),
        .RS1_BUSY(RS1_BUSY),
        .RS2_BUSY(RS2_BUSY)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int          m_ptr = 0;
    bit          m_busy [32];
    bit          m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          last_g = -1;

    function automatic int model_pick();
        if (RST) return -1;
        for (int k = 0; k < N; k++) begin
            if (REQ_VALID[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(m_we && (m_addr == a));
    endfunction

    task automatic model_clock();
        int g;
        g = model_pick();
        last_g = g;
        if (RST) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
        end else begin
            if (m_we) m_busy[m_addr] = 1'b0;
            if (ISSUE_VALID && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1'b1;
            if (g >= 0) begin
                m_addr = REQ_RD[g*AW +: AW];
                m_data = REQ_DATA[g*W +: W];
                m_we   = (m_addr != 0);
                m_ptr  = (g + 1) % N;
            end else begin
                m_we = 1'b0;
            end
        end
    endtask

    // Advance model and design together; inputs change 1 ns after the edge.
    task automatic tick();
        model_clock();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1; ISSUE_VALID = 1'b0; ISSUE_RD = '0;
        REQ_VALID = 3'b111; REQ_RD = {5'd3, 5'd2, 5'd1}; REQ_DATA = {3{32'h1234_5678}};
        RS1_ADDRESS = '0; RS2_ADDRESS = '0;
        #1;
        checks++;
        if (REQ_READY !== 3'b000) $display("FAIL reset_ready: got %b expected 000", REQ_READY);
        else passed++;
        tick();
        checks++;
        if (RD_WRITE_EN !== 1'b0) $display("FAIL reset_we: got %b expected 0", RD_WRITE_EN);
        else passed++;
        REQ_VALID = '0;
        for (int a = 0; a < 32; a++) begin
            RS1_ADDRESS = 5'(a);
            #1;
            checks++;
            if (RS1_BUSY !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", a, RS1_BUSY);
            else passed++;
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_single();
        REQ_VALID = 3'b010;
        REQ_RD[1*AW +: AW] = 5'd5;
        REQ_DATA[1*W +: W] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (REQ_READY !== 3'b010) $display("FAIL single_ready: got %b expected 010", REQ_READY);
        else passed++;
        tick();
        REQ_VALID = '0;
        checks++;
        if (RD_WRITE_EN !== 1'b1 || RD_ADDRESS !== 5'd5 || RD_DATA !== 32'hDEAD_BEEF)
            $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=5 data=deadbeef",
                     RD_WRITE_EN, RD_ADDRESS, RD_DATA);
        else passed++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        logic [31:0]  ed;
        int g;
        RST = 1'b1; tick(); RST = 1'b0;
        REQ_RD = {5'd12, 5'd11, 5'd10};
        REQ_DATA = {$urandom, $urandom, $urandom};
        REQ_VALID = 3'b111;
        for (int c = 0; c < 6; c++) begin
            g  = c % N;
            e  = 3'b001 << g;
            ed = REQ_DATA[g*W +: W];
            #1;
            checks++;
            if (REQ_READY !== e) $display("FAIL rr_grant[%0d]: got %b expected %b", c, REQ_READY, e);
            else passed++;
            tick();
            checks++;
            if (RD_WRITE_EN !== 1'b1 || RD_ADDRESS !== 5'(10 + g) || RD_DATA !== ed)
                $display("FAIL rr_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         c, RD_WRITE_EN, RD_ADDRESS, RD_DATA, 10 + g, ed);
            else passed++;
            REQ_DATA[g*W +: W] = $urandom;
        end
        REQ_VALID = '0;
        tick();
        checks++;
        if (RD_WRITE_EN !== 1'b0) $display("FAIL rr_idle_we: got %b expected 0", RD_WRITE_EN);
        else passed++;
    endtask

    task automatic test_scoreboard();
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
        tick();
        ISSUE_VALID = 1'b0;
        RS1_ADDRESS = 5'd7; RS2_ADDRESS = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (RS1_BUSY !== 1'b1 || RS2_BUSY !== 1'b1)
                $display("FAIL sb_pending[%0d]: got rs1=%b rs2=%b expected 1 1", c, RS1_BUSY, RS2_BUSY);
            else passed++;
            tick();
        end
        REQ_VALID = 3'b001; REQ_RD[0 +: AW] = 5'd7; REQ_DATA[0 +: W] = 32'h0000_0777;
        #1;
        checks++;
        if (RS1_BUSY !== 1'b1) $display("FAIL sb_before_wb: got %b expected 1", RS1_BUSY);
        else passed++;
        tick();
        REQ_VALID = '0;
        checks++;
        if (RD_WRITE_EN !== 1'b1 || RS1_BUSY !== 1'b0 || RS2_BUSY !== 1'b0)
            $display("FAIL sb_wb_cycle: got we=%b rs1=%b rs2=%b expected 1 0 0", RD_WRITE_EN, RS1_BUSY, RS2_BUSY);
        else passed++;
        tick();
        checks++;
        if (RS1_BUSY !== 1'b0) $display("FAIL sb_after_wb: got %b expected 0", RS1_BUSY);
        else passed++;
    endtask

    task automatic test_set_clear();
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
        tick();
        ISSUE_VALID = 1'b0;
        REQ_VALID = 3'b100; REQ_RD[2*AW +: AW] = 5'd9; REQ_DATA[2*W +: W] = 32'h0000_0999;
        tick();
        REQ_VALID = '0;
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9; RS1_ADDRESS = 5'd9;
        #1;
        checks++;
        if (RD_WRITE_EN !== 1'b1 || RD_ADDRESS !== 5'd9 || RS1_BUSY !== 1'b0)
            $display("FAIL setclr_overlap: got we=%b addr=%0d rs1=%b expected 1 9 0", RD_WRITE_EN, RD_ADDRESS, RS1_BUSY);
        else passed++;
        tick();
        ISSUE_VALID = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (RS1_BUSY !== 1'b1) $display("FAIL setclr_kept[%0d]: got %b expected 1", c, RS1_BUSY);
            else passed++;
            tick();
        end
    endtask

    task automatic test_x0_reset();
        REQ_VALID = 3'b100; REQ_RD[2*AW +: AW] = 5'd0; REQ_DATA[2*W +: W] = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (REQ_READY !== 3'b100) $display("FAIL x0_ready: got %b expected 100", REQ_READY);
        else passed++;
        tick();
        REQ_VALID = '0;
        checks++;
        if (RD_WRITE_EN !== 1'b0) $display("FAIL x0_we: got %b expected 0", RD_WRITE_EN);
        else passed++;
        REQ_VALID = 3'b010; REQ_RD[1*AW +: AW] = 5'd12; REQ_DATA[1*W +: W] = 32'hCAFE_0012;
        tick();
        REQ_VALID = 3'b111; RST = 1'b1;
        #1;
        checks++;
        if (REQ_READY !== 3'b000) $display("FAIL midrst_ready: got %b expected 000", REQ_READY);
        else passed++;
        tick();
        RST = 1'b0;
        #1;
        checks++;
        if (RD_WRITE_EN !== 1'b0 || RD_ADDRESS !== 5'd0 || RD_DATA !== 32'd0)
            $display("FAIL midrst_out: got we=%b addr=%0d data=%h expected 0 0 0", RD_WRITE_EN, RD_ADDRESS, RD_DATA);
        else passed++;
        checks++;
        if (REQ_READY !== 3'b001) $display("FAIL midrst_ptr: got %b expected 001", REQ_READY);
        else passed++;
        REQ_VALID = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 59) == 0);
            ISSUE_VALID = $urandom_range(0, 2) == 0;
            ISSUE_RD    = 5'($urandom_range(0, 15));
            RS1_ADDRESS = 5'($urandom_range(0, 15));
            RS2_ADDRESS = 5'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if (!REQ_VALID[i] && $urandom_range(0, 1) == 1) begin
                    REQ_VALID[i] = 1'b1;
                    REQ_RD[i*AW +: AW] = 5'($urandom_range(0, 15));
                    REQ_DATA[i*W +: W] = $urandom;
                end
            end
            #1;
            checks++;
            if (REQ_READY !== exp_ready()) $display("FAIL rnd_ready[%0d]: got %b expected %b", c, REQ_READY, exp_ready());
            else passed++;
            checks++;
            if (RS1_BUSY !== exp_busy(RS1_ADDRESS) || RS2_BUSY !== exp_busy(RS2_ADDRESS))
                $display("FAIL rnd_busy[%0d]: got rs1=%b rs2=%b expected %b %b", c, RS1_BUSY, RS2_BUSY,
                         exp_busy(RS1_ADDRESS), exp_busy(RS2_ADDRESS));
            else passed++;
            tick();
            if (last_g >= 0) REQ_VALID[last_g] = 1'b0;
            checks++;
            if (RD_WRITE_EN !== m_we || RD_ADDRESS !== m_addr || RD_DATA !== m_data)
                $display("FAIL rnd_write[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                         c, RD_WRITE_EN, RD_ADDRESS, RD_DATA, m_we, m_addr, m_data);
            else passed++;
        end
        RST = 1'b0; ISSUE_VALID = 1'b0; REQ_VALID = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_set_clear();
        test_x0_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
